serv_seq_ctrl: RTL and testbench

//  Instruction-phase sequencer for the serial core, parametrised in datapath width W.

---
 rtl/serv_seq_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_serv_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_seq_ctrl.sv
// serv_seq_ctrl: instruction-phase sequencer for the serial core.
// Runs the IDLE/INIT/RUN/TRAP/MEM state machine, the bit counter and its
// phase-done strobe, plus the timer-IRQ pending flag and trap-cause capture.
// A phase lasts 32/W cycles; W must be 1, 2, 4 or 8.
module serv_seq_ctrl #(
    parameter int W        = 1,
    parameter bit WITH_IRQ = 1'b1
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_rf_ready,
    input  logic       i_two_stage_op,
    input  logic       i_mem_op,
    input  logic       i_e_op,
    input  logic       i_take_branch,
    input  logic       i_mem_misalign,
    input  logic       i_ctrl_misalign,
    input  logic       i_dbus_ack,
    input  logic       i_dbus_err,
    input  logic       i_mtip,
    input  logic       i_timer_irq_en,
    output logic [4:0] o_cnt,
    output logic [3:0] o_cnt_r,
    output logic       o_cnt_en,
    output logic       o_cnt_done,
    output logic       o_init,
    output logic       o_run,
    output logic       o_trap,
    output logic       o_dbus_cyc,
    output logic       o_ctrl_jump,
    output logic       o_pending_irq,
    output logic [1:0] o_trap_cause
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_TRAP = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;

    localparam logic [1:0] CAUSE_EOP   = 2'b00;
    localparam logic [1:0] CAUSE_IRQ   = 2'b01;
    localparam logic [1:0] CAUSE_MEM   = 2'b10;
    localparam logic [1:0] CAUSE_CTRL  = 2'b11;

    localparam logic [4:0] CNT_STEP = 5'(W);
    localparam logic [4:0] CNT_LAST = 5'(32 - W);
    localparam int         ROT      = W % 4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [4:0] cnt;
    logic [4:0] cnt_nxt;
    logic [3:0] cnt_r;
    logic [3:0] cnt_r_rot;
    logic       cnt_en;
    logic       cnt_en_nxt;
    logic       cnt_done;
    logic       ctrl_jump;
    logic       stage_one_done;
    logic       pending_irq;
    logic       mtip_r;
    logic       irq_set;
    logic       cause_load;
    logic [1:0] cause_nxt;
    logic [1:0] trap_cause;

    assign cnt_en     = (state == S_INIT) || (state == S_RUN) || (state == S_TRAP);
    assign cnt_en_nxt = (state_nxt == S_INIT) || (state_nxt == S_RUN) || (state_nxt == S_TRAP);

    // The counter is forced back to 0 on the last slice so IDLE/MEM always see 0.
    assign cnt_nxt = (cnt_en && !cnt_done) ? cnt + CNT_STEP : 5'd0;

    // One-hot nibble position rotates by W; for W >= 4 a whole nibble is one slice.
    generate
        if (ROT == 1) begin : g_rot1
            assign cnt_r_rot = {cnt_r[2:0], cnt_r[3]};
        end else if (ROT == 2) begin : g_rot2
            assign cnt_r_rot = {cnt_r[1:0], cnt_r[3:2]};
        end else begin : g_rot0
            assign cnt_r_rot = cnt_r;
        end
    endgenerate

    // Only a rising timer edge raises a request, so a held level cannot retrigger.
    assign irq_set = WITH_IRQ && i_mtip && !mtip_r && i_timer_irq_en;

    // Next-state selection and trap-cause choice.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt  = state;
        cause_load = 1'b0;
        cause_nxt  = trap_cause;
        case (state)
            S_IDLE: begin
                if (i_rf_ready) begin
                    if (pending_irq) begin
                        state_nxt  = S_TRAP;
                        cause_load = 1'b1;
                        cause_nxt  = CAUSE_IRQ;
                    end else if (i_e_op) begin
                        state_nxt  = S_TRAP;
                        cause_load = 1'b1;
                        cause_nxt  = CAUSE_EOP;
                    end else if (i_two_stage_op && !stage_one_done) begin
                        state_nxt = S_INIT;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_INIT: begin
                if (cnt_done) begin
                    if (i_mem_misalign) begin
                        state_nxt  = S_TRAP;
                        cause_load = 1'b1;
                        cause_nxt  = CAUSE_MEM;
                    end else if (i_take_branch && i_ctrl_misalign) begin
                        state_nxt  = S_TRAP;
                        cause_load = 1'b1;
                        cause_nxt  = CAUSE_CTRL;
                    end else if (i_mem_op) begin
                        state_nxt = S_MEM;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_MEM: begin
                if (i_dbus_err) begin
                    state_nxt  = S_TRAP;
                    cause_load = 1'b1;
                    cause_nxt  = CAUSE_MEM;
                end else if (i_dbus_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN, S_TRAP: begin
                if (cnt_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, bit counter and registered phase-done strobe.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= 5'd0;
            cnt_r    <= 4'b0001;
            cnt_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cnt_r    <= cnt_en ? cnt_r_rot : cnt_r;
            cnt_done <= cnt_en_nxt && (cnt_nxt == CNT_LAST);
        end
    end

    // Branch decision, two-stage bookkeeping and trap cause.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl_jump      <= 1'b0;
            stage_one_done <= 1'b0;
            trap_cause     <= CAUSE_EOP;
        end else begin
            if (state == S_IDLE) begin
                ctrl_jump <= 1'b0;
            end else if (state == S_INIT) begin
                ctrl_jump <= i_take_branch;
            end
            if (state == S_INIT) begin
                stage_one_done <= 1'b1;
            end else if ((state == S_RUN || state == S_TRAP) && cnt_done) begin
                stage_one_done <= 1'b0;
            end
            if (cause_load) begin
                trap_cause <= cause_nxt;
            end
        end
    end

    // Timer interrupt pending flag; a new edge beats the end-of-trap clear.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            mtip_r      <= 1'b0;
            pending_irq <= 1'b0;
        end else begin
            mtip_r <= i_mtip;
            if (irq_set) begin
                pending_irq <= 1'b1;
            end else if (state == S_TRAP && cnt_done) begin
                pending_irq <= 1'b0;
            end
        end
    end

    assign o_cnt         = cnt;
    assign o_cnt_r       = cnt_r;
    assign o_cnt_en      = cnt_en;
    assign o_cnt_done    = cnt_done;
    assign o_init        = (state == S_INIT);
    assign o_run         = (state == S_RUN);
    assign o_trap        = (state == S_TRAP);
    assign o_dbus_cyc    = (state == S_MEM);
    assign o_ctrl_jump   = ctrl_jump;
    assign o_pending_irq = pending_irq;
    assign o_trap_cause  = trap_cause;

endmodule

// File: tb/tb_serv_seq_ctrl.sv
// tb_serv_seq_ctrl: scoreboard bench for serv_seq_ctrl at W = 1, 2 and 4.
// The driver queues the expected per-cycle outputs of each active phase;
// a monitor pops and compares whenever the selected DUT is busy.
module tb_serv_seq_ctrl;

    logic clk = 1'b0;
    logic i_rst;
    always #5 clk = ~clk;

    logic rf_ready [3];
    logic irq_en   [3];
    logic two_stage, mem_op, e_op, take_branch, mem_mis, ctrl_mis, ack, err, mtip;

    logic [4:0] cnt_a   [3];
    logic [3:0] cnt_r_a [3];
    logic [1:0] cause_a [3];
    logic cnt_en_a [3], done_a [3], init_a [3], run_a [3], trap_a [3];
    logic dbus_a [3], jump_a [3], pend_a [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            serv_seq_ctrl #(
                .W        (g == 0 ? 1 : (g == 1 ? 2 : 4)),
                .WITH_IRQ (1'b1)
            ) u_dut (
                .clk             (clk),
                .i_rst           (i_rst),
                .i_rf_ready      (rf_ready[g]),
                .i_two_stage_op  (two_stage),
                .i_mem_op        (mem_op),
                .i_e_op          (e_op),
                .i_take_branch   (take_branch),
                .i_mem_misalign  (mem_mis),
                .i_ctrl_misalign (ctrl_mis),
                .i_dbus_ack      (ack),
                .i_dbus_err      (err),
                .i_mtip          (mtip),
                .i_timer_irq_en  (irq_en[g]),
                .o_cnt           (cnt_a[g]),
                .o_cnt_r         (cnt_r_a[g]),
                .o_cnt_en        (cnt_en_a[g]),
                .o_cnt_done      (done_a[g]),
                .o_init          (init_a[g]),
                .o_run           (run_a[g]),
                .o_trap          (trap_a[g]),
                .o_dbus_cyc      (dbus_a[g]),
                .o_ctrl_jump     (jump_a[g]),
                .o_pending_irq   (pend_a[g]),
                .o_trap_cause    (cause_a[g])
            );
        end
    endgenerate

    typedef struct {
        string       name;
        logic [18:0] val;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sel      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    // {init,run,trap,dbus,cnt_en,cnt[4:0],cnt_r[3:0],done,jump,pending,cause[1:0]}
    function automatic logic [18:0] obs_of(input int k);
        return {init_a[k], run_a[k], trap_a[k], dbus_a[k], cnt_en_a[k], cnt_a[k],
                cnt_r_a[k], done_a[k], jump_a[k], pend_a[k], cause_a[k]};
    endfunction

    // st: 0 idle, 1 init, 2 run, 3 trap, 4 mem
    function automatic logic [18:0] mk(input int st, input logic [4:0] c, input logic [3:0] cr,
                                       input logic d, input logic j, input logic p,
                                       input logic [1:0] cause);
        logic en;
        en = (st == 1) || (st == 2) || (st == 3);
        return {st == 1, st == 2, st == 3, st == 4, en, c, cr, d, j, p, cause};
    endfunction

    task automatic push_phase(input string nm, input int st, input int w, input int n,
                              input int jump_from, input int pend_from, input logic [1:0] cause);
        exp_t e;
        logic [3:0] cr;
        for (int i = 0; i < n; i++) begin
            if (w == 1)      cr = 4'(1 << (i % 4));
            else if (w == 2) cr = (i % 2 == 1) ? 4'b0100 : 4'b0001;
            else             cr = 4'b0001;
            e.name = $sformatf("%s[%0d]", nm, i);
            e.val  = mk(st, 5'(i * w), cr, (i * w) == (32 - w), i >= jump_from, i >= pend_from, cause);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_mem(input string nm, input int n, input logic p, input logic [1:0] cause);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.name = $sformatf("%s[%0d]", nm, i);
            e.val  = mk(4, 5'd0, 4'b0001, 1'b0, 1'b0, p, cause);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input int k, input string nm, input logic j, input logic p,
                              input logic [1:0] cause);
        check(nm, 32'(obs_of(k)), 32'(mk(0, 5'd0, 4'b0001, 1'b0, j, p, cause)));
    endtask

    task automatic drain(input string nm);
        check(nm, 32'(exp_q.size()), 32'd0);
    endtask

    // Issue one rf_ready pulse to instance k and advance to the first busy cycle.
    task automatic kick(input int k);
        rf_ready[k] = 1'b1;
        step();
        rf_ready[k] = 1'b0;
    endtask

    // Monitor: every busy cycle of the selected DUT consumes one expected entry.
    always @(negedge clk) begin
        if (i_rst === 1'b0 && (cnt_en_a[sel] === 1'b1 || dbus_a[sel] === 1'b1)) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check("spurious_active", 32'(obs_of(sel)), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check(e.name, 32'(obs_of(sel)), 32'(e.val));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rf_ready[k] = 1'b0;
            irq_en[k]   = 1'b0;
        end
        {two_stage, mem_op, e_op, take_branch, mem_mis, ctrl_mis, ack, err, mtip} = '0;
        i_rst = 1'b1;
        step();
        for (int k = 0; k < 3; k++) idle_check(k, $sformatf("reset_%0d", k), 1'b0, 1'b0, 2'b00);
        step();
        i_rst = 1'b0;
        step();

        // W=1 plain op: RUN 32 cycles then IDLE.
        sel = 0;
        push_phase("a_run", 2, 1, 32, 32, 32, 2'b00);
        kick(0);
        repeat (32) step();
        idle_check(0, "a_idle", 1'b0, 1'b0, 2'b00);
        drain("a_drain");

        // W=4 load: INIT 8, MEM 3 until ack, IDLE, then writeback RUN 8.
        sel = 2;
        two_stage = 1'b1;
        mem_op    = 1'b1;
        push_phase("b_init", 1, 4, 8, 8, 8, 2'b00);
        push_mem("b_mem", 3, 1'b0, 2'b00);
        kick(2);
        repeat (10) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        idle_check(2, "b_idle", 1'b0, 1'b0, 2'b00);
        drain("b_drain");
        push_phase("b_wb", 2, 4, 8, 8, 8, 2'b00);
        kick(2);
        repeat (8) step();
        idle_check(2, "b_wb_idle", 1'b0, 1'b0, 2'b00);
        drain("b_wb_drain");
        two_stage = 1'b0;
        mem_op    = 1'b0;

        // W=2 branch with misaligned taken target on the last INIT slice.
        sel = 1;
        two_stage = 1'b1;
        push_phase("c_init", 1, 2, 16, 16, 16, 2'b00);
        push_phase("c_trap", 3, 2, 16, 0, 16, 2'b11);
        kick(1);
        repeat (15) step();
        take_branch = 1'b1;
        ctrl_mis    = 1'b1;
        step();
        take_branch = 1'b0;
        ctrl_mis    = 1'b0;
        repeat (16) step();
        idle_check(1, "c_idle", 1'b1, 1'b0, 2'b11);
        step();
        idle_check(1, "c_idle_jclr", 1'b0, 1'b0, 2'b11);
        drain("c_drain");
        two_stage = 1'b0;

        // W=4 timer IRQ raised mid-RUN, serviced on next rf_ready, level held.
        sel = 2;
        irq_en[2] = 1'b1;
        push_phase("d_run", 2, 4, 8, 8, 3, 2'b00);
        kick(2);
        repeat (2) step();
        mtip = 1'b1;
        repeat (6) step();
        idle_check(2, "d_idle_pend", 1'b0, 1'b1, 2'b00);
        push_phase("d_trap", 3, 4, 8, 8, 0, 2'b01);
        kick(2);
        repeat (8) step();
        idle_check(2, "d_after_trap", 1'b0, 1'b0, 2'b01);
        repeat (3) step();
        idle_check(2, "d_level_held", 1'b0, 1'b0, 2'b01);
        push_phase("d_no_retrig", 2, 4, 8, 8, 8, 2'b01);
        kick(2);
        repeat (8) step();
        drain("d_drain");

        // W=4 ecall trap with a fresh timer edge in its final cycle.
        mtip = 1'b0;
        repeat (2) step();
        push_phase("e_trap", 3, 4, 8, 8, 8, 2'b00);
        e_op = 1'b1;
        kick(2);
        e_op = 1'b0;
        repeat (7) step();
        mtip = 1'b1;
        step();
        idle_check(2, "e_set_wins", 1'b0, 1'b1, 2'b00);
        push_phase("e_trap2", 3, 4, 8, 8, 0, 2'b01);
        kick(2);
        repeat (8) step();
        idle_check(2, "e_after", 1'b0, 1'b0, 2'b01);
        drain("e_drain");
        mtip      = 1'b0;
        irq_en[2] = 1'b0;

        // W=1 async reset in the middle of INIT at cnt=12.
        sel = 0;
        two_stage   = 1'b1;
        take_branch = 1'b1;
        push_phase("f_init", 1, 1, 13, 1, 32, 2'b00);
        kick(0);
        repeat (12) step();
        @(negedge clk);
        #1;
        i_rst = 1'b1;
        #1;
        idle_check(0, "f_async_rst", 1'b0, 1'b0, 2'b00);
        repeat (2) step();
        i_rst       = 1'b0;
        two_stage   = 1'b0;
        take_branch = 1'b0;
        step();
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
